// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: the WIDTH-bit carry chain is cut into STAGES
// registered slices with a skewed operand pipeline and full valid/ready backpressure.
module pipelined_addsub #(
  parameter int WIDTH  = 32,  // must be a multiple of STAGES
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ovf_q, zero_q, neg_q;

  logic [WIDTH-1:0]  bx;
  logic              c0;

  assign bx = in_sub ? ~in_b : in_b;
  assign c0 = in_cin ^ in_sub;

  // A stage may load when it is empty or its content moves on this cycle.
  // NOTE: every variable written here gets a value before any read on all paths, so no latch is inferred.
  always_comb begin
    logic chain;
    chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain = !vld[k] || chain;
      en[k] = chain;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int P = (k == 0) ? 0 : k - 1;  // feeding stage; stage 0 is fed by the ports

    logic [SW-1:0]    sa, sb;
    logic             ci, up_v;
    logic [WIDTH-1:0] s_in, s_nxt;
    logic [SW:0]      slice;

    assign sa   = (k == 0) ? in_a[SW-1:0] : a_q[P][k*SW +: SW];
    assign sb   = (k == 0) ? bx[SW-1:0]   : b_q[P][k*SW +: SW];
    assign ci   = (k == 0) ? c0           : c_q[P];
    assign up_v = (k == 0) ? in_valid     : vld[P];
    assign s_in = (k == 0) ? '0           : s_q[P];

    assign slice = {1'b0, sa} + {1'b0, sb} + {{SW{1'b0}}, ci};
    // Upper bits of s_in are still zero, so the new slice is simply OR-ed in place.
    assign s_nxt = s_in | (WIDTH'(slice[SW-1:0]) << (k * SW));

    // NOTE: sequential state uses non-blocking assignments; data registers are reset too
    // because the cleared result and flags are visible on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld[k] <= 1'b0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end else if (en[k]) begin
        vld[k] <= up_v;
        if (up_v) begin
          s_q[k] <= s_nxt;
          c_q[k] <= slice[SW];
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end else if (en[k] && up_v) begin
          a_q[k] <= (k == 0) ? in_a : a_q[P];
          b_q[k] <= (k == 0) ? bx   : b_q[P];
        end
      end
    end

    if (k == STAGES - 1) begin : g_flags
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (en[k] && up_v) begin
          // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
          ovf_q  <= sa[SW-1] ^ sb[SW-1] ^ slice[SW-1] ^ slice[SW];
          zero_q <= (s_nxt == '0);
          neg_q  <= s_nxt[WIDTH-1];
        end
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = vld[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: a 32-bit/4-stage unit and an 8-bit/1-stage unit.
module tb_pipelined_addsub;

  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_sub, in_cin;
  logic          out_valid, out_ready, out_cout, out_ovf, out_zero, out_neg;
  logic [W-1:0]  in_a, in_b, out_sum;

  logic          e_in_valid, e_in_ready, e_in_sub, e_in_cin;
  logic          e_out_valid, e_out_ready, e_out_cout, e_out_ovf, e_out_zero, e_out_neg;
  logic [7:0]    e_in_a, e_in_b, e_out_sum;

  int vectors = 0;
  int errors  = 0;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_a(e_in_a), .in_b(e_in_b),
    .in_sub(e_in_sub), .in_cin(e_in_cin),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_sum(e_out_sum),
    .out_cout(e_out_cout), .out_ovf(e_out_ovf), .out_zero(e_out_zero), .out_neg(e_out_neg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    logic [31:0] bx;
    logic [32:0] full;
    logic        ovf;
    bx   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {32'd0, cin ^ sub};
    ovf  = (a[31] == bx[31]) && (full[31] != a[31]);
    return {full[31:0], full[32], ovf, full[31:0] == 32'd0, full[31]};
  endfunction

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin, input logic [31:0] esum,
                         input logic [3:0] eflags);
    int cyc;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    #1 check({tag, " in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, S);
    check({tag, " sum"}, out_sum, esum);
    check({tag, " cout/ovf/zero/neg"}, {out_cout, out_ovf, out_zero, out_neg}, eflags);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sa [10];
    logic [31:0] sb [10];
    logic        ssub [10];
    logic        scin [10];
    logic [35:0] exp_q [$];
    logic [35:0] held;
    logic        held_valid;
    int          beat, inflight, cyc, stall_cycles, n_out, first_cyc;
    logic [31:0] first_sum;

    rst_n = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
    e_in_valid = 1'b0; e_in_a = '0; e_in_b = '0; e_in_sub = 1'b0; e_in_cin = 1'b0; e_out_ready = 1'b1;

    // Asynchronous reset before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("reset out32", {out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg}, '0);
    check("reset in_ready32", in_ready, 1'b1);
    check("reset out8", {e_out_valid, e_out_sum, e_out_cout, e_out_ovf, e_out_zero, e_out_neg}, '0);
    check("reset in_ready8", e_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single beats; flags packed as {cout, ovf, zero, neg}.
    run_one("add wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010);
    run_one("sub ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b1100);
    run_one("borrow in",   32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0001);
    run_one("add plain",   32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 4'b0000);
    run_one("add pos ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101);
    run_one("sub equal",   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000, 4'b1010);

    // Back-to-back stream with a 6-cycle output stall.
    for (int i = 0; i < 10; i++) begin
      sa[i] = $urandom; sb[i] = $urandom;
      ssub[i] = 1'($urandom_range(1)); scin[i] = 1'($urandom_range(1));
    end
    beat = 0; inflight = 0; cyc = 0; stall_cycles = 0; held_valid = 1'b0; held = '0;
    while ((beat < 10 || exp_q.size() > 0) && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 12);
      if (beat < 10) begin
        in_valid = 1'b1; in_a = sa[beat]; in_b = sb[beat]; in_sub = ssub[beat]; in_cin = scin[beat];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("stream in_ready", in_ready, (inflight != S) || out_ready);
      if (!in_ready) stall_cycles++;
      if (held_valid)
        check("stall hold", {out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg}, {1'b1, held});
      held_valid = out_valid && !out_ready;
      held = {out_sum, out_cout, out_ovf, out_zero, out_neg};
      if (out_valid && out_ready) begin
        check("stream beat expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          check("stream result", {out_sum, out_cout, out_ovf, out_zero, out_neg}, exp_q.pop_front());
          inflight--;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
        inflight++;
        beat++;
      end
      cyc++;
    end
    check("stream drained", 32'(exp_q.size()) + 32'(10 - beat), 0);
    check("stream in_ready low cycles", stall_cycles, 6);
    out_ready = 1'b1;
    in_valid = 1'b0;

    // Reset with three beats in flight: none of them may emerge.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'h100 * (i + 1); in_b = 32'h1; in_sub = 1'b0; in_cin = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset out", {out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg}, '0);
    check("midreset in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_a = 32'h10; in_b = 32'h20; in_sub = 1'b0; in_cin = 1'b0;
    #1 check("midreset accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_out = 0; first_cyc = 0; first_sum = '0;
    for (int i = 1; i <= 8; i++) begin
      if (out_valid) begin
        if (n_out == 0) begin
          first_cyc = i;
          first_sum = out_sum;
        end
        n_out++;
      end
      @(negedge clk);
    end
    check("midreset beats out", n_out, 1);
    check("midreset latency", first_cyc, S);
    check("midreset sum", first_sum, 32'h30);

    // WIDTH=8, STAGES=1 corner: 0x7F + 0x01.
    @(negedge clk);
    e_in_valid = 1'b1; e_in_a = 8'h7F; e_in_b = 8'h01; e_in_sub = 1'b0; e_in_cin = 1'b0;
    #1 check("w8 in_ready", e_in_ready, 1'b1);
    @(negedge clk);
    e_in_valid = 1'b0;
    check("w8 latency1 valid", e_out_valid, 1'b1);
    check("w8 sum", e_out_sum, 8'h80);
    check("w8 cout/ovf/zero/neg", {e_out_cout, e_out_ovf, e_out_zero, e_out_neg}, 4'b0101);
    @(negedge clk);
    check("w8 consumed", e_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
